fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Parametrised instruction fetch stage: the instruction store, its program-load path, the PC and next-fetch selection.
- Sits between the program loader (UART receiver) and decode.
- Runs one instruction per cycle with zero-bubble redirect on jump and predicted-taken branch.
- Adds an explicit LOAD/RUN state machine, flush redirect, and optional return-address-stack prediction for jr.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 14, instruction address width; store depth is 2**ADDR_WIDTH.
- RAS_DEPTH, 8, return-address stack entries (power of two, >=2; used only with FETCH_RAS_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; returns block to LOAD
- load_valid  in  1  load_data valid this cycle (LOAD only)
- load_data  in  INST_WIDTH  instruction word to store
- load_done  in  1  program complete; LOAD->RUN
- loading  out  1  high while in LOAD
- stall  in  1  hold fetch state
- flush  in  1  misprediction redirect from execute
- flush_addr  in  ADDR_WIDTH  correct next-instruction address
- dec_is_j  in  1  out_inst is an unconditional jump
- dec_is_b  in  1  out_inst is a conditional branch
- dec_is_call  in  1  out_inst is jal (link)
- dec_is_jr  in  1  out_inst is jr
- dec_target  in  ADDR_WIDTH  immediate target of out_inst
- predict_taken  in  1  branch predictor verdict for out_inst
- return_addr  in  ADDR_WIDTH  link register value (jr target source without RAS or on RAS empty)
- out_valid  out  1  out_inst/out_pc valid
- out_inst  out  INST_WIDTH  fetched instruction
- out_pc  out  ADDR_WIDTH  address of out_inst

Behaviour:
- Reset: state=LOAD, load_ptr=0, pc=0, out_valid=0, out_inst=0, out_pc=0, loading=1, RAS count=0.
- Store: distributed RAM; 1 sync write port, async reads at pc, dec_target, jr-target, flush_addr.
- LOAD:
  - load_valid writes mem[load_ptr]; load_ptr++ mod depth; wraps silently.
  - out_valid=0.
  - load_done (same cycle as load_valid allowed; the write still happens) -> RUN with pc=0.
- RUN entry: first cycle fetches mem[0]; out_pc=0, out_valid=1, pc=1. load_valid and load_done are ignored in RUN.
- Next-fetch address A, priority order:
  - flush -> A=flush_addr (overrides stall).
  - stall -> hold pc, out_inst, out_pc, out_valid, RAS.
  - dec_is_j, or dec_is_b && predict_taken -> A=dec_target.
  - dec_is_jr -> A=jr-target.
  - else A=pc.
  - Register updates: out_inst<=mem[A], out_pc<=A, pc<=A+1 mod depth.
- Decode inputs describe the current out_inst. Redirect costs zero bubbles: the target is fetched in the cycle after the jump is presented.
- dec_is_* are qualified by out_valid; all ignored when out_valid=0.
- Address wrap: pc at 2**ADDR_WIDTH-1 increments to 0.
- reset mid-RUN or mid-LOAD: immediate return to LOAD, store contents retained.

Optional Feature:
- Macro: FETCH_RAS_EN.
- Defined:
  - Circular RAS of RAS_DEPTH entries, top pointer and saturating count.
  - Push out_pc+1 on accepted dec_is_call (not stalled, not flushed).
  - Pop on accepted dec_is_jr; jr-target = popped top.
  - If count==0, jr-target = return_addr and no pop.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - dec_is_call and dec_is_jr together: push only.
  - flush leaves the RAS unchanged; a wrong target is corrected by a later flush.
- Undefined: no RAS logic; jr-target = return_addr always; dec_is_call is ignored.

Decomposition:
- Shared package common: INST_WIDTH and ADDR_WIDTH defaults, fetch_state_t enum {LOAD, RUN}, inst_addr_t typedef.
- One natural sub-module: ras_stack, instantiated only under FETCH_RAS_EN.
  - Inputs: push, pop, push_data.
  - Outputs: top, empty.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44, then load_done -> loading falls; next cycles out_inst=0x11,0x22,0x33 with out_pc=0,1,2, out_valid=1.
- At out_pc=1, dec_is_j with dec_target=3 -> following cycle out_pc=3, out_inst=0x44, with no gap cycle.
- Branch at out_pc=0, target 2: predict_taken=0 gives out_pc=1; predict_taken=1 gives out_pc=2.
- Stall held 3 cycles with flush=1, flush_addr=2 in the 2nd cycle -> next cycle out_pc=2; outputs otherwise unchanged during the stall.
- FETCH_RAS_EN: calls at pc 5 and 9, then two jr with return_addr=0 -> targets 10, then 6. A third jr targets return_addr. RAS_DEPTH+1 nested calls return to the newest RAS_DEPTH return addresses, newest first; the next jr then falls back to return_addr.
- reset asserted mid-RUN -> next cycle loading=1, out_valid=0; reload writes starting at address 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the LOAD/RUN state encoding and the instruction address type.
package fetch_unit_pkg;

  localparam int unsigned INST_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 14;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef logic [ADDR_WIDTH_DEF-1:0] inst_addr_t;

endpackage

// File: rtl/fetch_unit_ras.sv
// Circular return-address stack with saturating occupancy count.
// Pushing when full silently overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    ptr_inc = ptr_q + 1'b1;
    // push has priority; the caller never asserts both for a call+jr pair
    if (push) begin
      stack_d[ptr_inc] = push_data;
      ptr_d            = ptr_inc;
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + 1'b1;
      end
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      stack_q <= stack_d;
    end
  end

  assign top   = stack_q[ptr_q];
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program store with load path, PC and next-fetch
// selection. Optional jr prediction via return-address stack (FETCH_RAS_EN).
module fetch_unit #(
  parameter int unsigned INST_WIDTH = fetch_unit_pkg::INST_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = fetch_unit_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned RAS_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic                  load_done,
  output logic                  loading,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  input  logic                  dec_is_j,
  input  logic                  dec_is_b,
  input  logic                  dec_is_call,
  input  logic                  dec_is_jr,
  input  logic [ADDR_WIDTH-1:0] dec_target,
  input  logic                  predict_taken,
  input  logic [ADDR_WIDTH-1:0] return_addr,
  output logic                  out_valid,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [INST_WIDTH-1:0] out_inst_q, out_inst_d;
  logic                  out_valid_q, out_valid_d;

  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] jr_target;
  logic                  run;
  logic                  dec_ok;
  logic                  take_target;
  logic                  take_jr;
  logic                  advance;

  // Decode inputs describe out_inst, so they only count once it is valid.
  always_comb begin
    run         = (state_q == RUN);
    dec_ok      = run && out_valid_q;
    take_target = dec_ok && (dec_is_j || (dec_is_b && predict_taken));
    take_jr     = dec_ok && !take_target && dec_is_jr;
    advance     = run && (flush || !stall);
    mem_we      = !reset && (state_q == LOAD) && load_valid;

    if (flush) begin
      fetch_addr = flush_addr;
    end else if (take_target) begin
      fetch_addr = dec_target;
    end else if (take_jr) begin
      fetch_addr = jr_target;
    end else begin
      fetch_addr = pc_q;
    end
  end

`ifdef FETCH_RAS_EN
  logic                  ras_accept;
  logic                  ras_push;
  logic                  ras_pop;
  logic                  ras_empty;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [ADDR_WIDTH-1:0] ras_push_data;

  always_comb begin
    ras_accept    = dec_ok && !stall && !flush;
    ras_push      = ras_accept && dec_is_call;
    ras_pop       = ras_accept && take_jr && !dec_is_call && !ras_empty;
    ras_push_data = out_pc_q + 1'b1;
  end

  assign jr_target = ras_empty ? return_addr : ras_top;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ras_push_data),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras;
  assign unused_ras = dec_is_call ^ (RAS_DEPTH != 0);
  assign jr_target  = return_addr;
`endif

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      LOAD: begin
        out_valid_d = 1'b0;
        if (load_valid) begin
          load_ptr_d = load_ptr_q + 1'b1;
        end
        if (load_done) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (advance) begin
          out_inst_d  = mem[fetch_addr];
          out_pc_d    = fetch_addr;
          pc_d        = fetch_addr + 1'b1;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD;
      load_ptr_q  <= '0;
      pc_q        <= '0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Store contents survive reset so a reset does not lose the program.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[load_ptr_q] <= load_data;
    end
  end

  assign loading   = (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pc    = out_pc_q;

endmodule
